// File: rtl/jk_pkg.sv
// Shared types and constants for the JK-cell synchronous counter.
package jk_pkg;

    // Counter operating mode, as presented on the mode input
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_UP   = 2'b01,
        JK_DOWN = 2'b10,
        JK_LOAD = 2'b11
    } jk_mode_e;

    // JK cell actions, encoded as {j, k}
    localparam logic [1:0] JK_NOP = 2'b00;
    localparam logic [1:0] JK_SET = 2'b10;
    localparam logic [1:0] JK_CLR = 2'b01;
    localparam logic [1:0] JK_TGL = 2'b11;

endpackage

// File: rtl/jk_sync_counter_if.sv
// Control/status bundle of the JK synchronous counter.
interface jk_sync_counter_if #(
    parameter int unsigned WIDTH = 8
);
    import jk_pkg::*;

    logic             en;
    jk_mode_e         mode;
    logic [WIDTH-1:0] load_val;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_n;
    logic             wrap;
    logic             ovf;

    // Controller side: drives commands, observes count and flags
    modport master (
        output en, mode, load_val, ovf_clr,
        input  count, count_n, wrap, ovf
    );

    // Counter side
    modport slave (
        input  en, mode, load_val, ovf_clr,
        output count, count_n, wrap, ovf
    );

endinterface

// File: rtl/jk_ff_cell.sv
// Single-bit JK flip-flop with asynchronous active-low reset to a per-cell value.
module jk_ff_cell
    import jk_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic rst_val,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    // JK truth table: hold, set, clear, toggle
    always_comb begin
        q_d = q_q;
        unique case ({j, k})
            JK_NOP:  q_d = q_q;
            JK_SET:  q_d = 1'b1;
            JK_CLR:  q_d = 1'b0;
            JK_TGL:  q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= rst_val;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// WIDTH-bit synchronous up/down/load counter built from JK flip-flop cells,
// with a one-cycle wrap pulse and a sticky overflow flag.
// Build option: define JK_SATURATE_EN to saturate at the limits instead of wrapping.
module jk_sync_counter
    import jk_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    jk_sync_counter_if.slave  bus
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] ones_below;
    logic [WIDTH-1:0] zeros_below;
    logic             wrap_event;
    logic             limit_hold;
    logic             wrap_q;
    logic             wrap_d;
    logic             ovf_q;
    logic             ovf_d;

    // Prefix masks: bit i toggles counting up when all lower bits are 1, down when all are 0
    always_comb begin
        ones_below     = '0;
        zeros_below    = '0;
        ones_below[0]  = 1'b1;
        zeros_below[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            ones_below[i]  = ones_below[i-1] & q[i-1];
            zeros_below[i] = zeros_below[i-1] & ~q[i-1];
        end
    end

    assign wrap_event = bus.en & (((bus.mode == JK_UP) & (&q)) |
                                  ((bus.mode == JK_DOWN) & ~(|q)));

`ifdef JK_SATURATE_EN
    assign limit_hold = wrap_event;
`else
    assign limit_hold = 1'b0;
`endif

    // J/K steering per mode; disabled or saturated cycles leave every cell at NOP
    always_comb begin
        j = '0;
        k = '0;
        if (bus.en && !limit_hold) begin
            unique case (bus.mode)
                JK_HOLD: begin
                    j = '0;
                    k = '0;
                end
                JK_UP: begin
                    j = ones_below;
                    k = ones_below;
                end
                JK_DOWN: begin
                    j = zeros_below;
                    k = zeros_below;
                end
                JK_LOAD: begin
                    j = bus.load_val;
                    k = ~bus.load_val;
                end
                default: begin
                    j = '0;
                    k = '0;
                end
            endcase
        end
    end

    // Counter bits, one JK cell each
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_ff_cell u_cell (
            .clock   (clock),
            .reset_n (reset_n),
            .rst_val (RESET_VAL[g]),
            .j       (j[g]),
            .k       (k[g]),
            .q       (q[g])
        );
    end

    // Flag next-state: a same-cycle event beats ovf_clr; ovf_clr ignores en
    always_comb begin
        wrap_d = wrap_event;
        ovf_d  = ovf_q;
        if (wrap_event) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Flag registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.count   = q;
    assign bus.count_n = ~q;
    assign bus.wrap    = wrap_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Self-checking bench for jk_sync_counter (WIDTH=4) against an arithmetic reference model.
module tb_jk_sync_counter;
    import jk_pkg::*;

    localparam int unsigned WIDTH = 4;
    localparam int          MAXV  = 15;

    logic clock;
    logic reset_n;

    jk_sync_counter_if #(.WIDTH(WIDTH)) bus ();

    jk_sync_counter #(
        .WIDTH     (WIDTH),
        .RESET_VAL (4'h0)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference state
    int m_count;
    int m_wrap;
    int m_ovf;

`ifdef JK_SATURATE_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_wrap  = 0;
        m_ovf   = 0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare
    task automatic step(input logic e, input jk_mode_e m, input int lv, input logic clr);
        int ev;
        bus.en       = e;
        bus.mode     = m;
        bus.load_val = lv[3:0];
        bus.ovf_clr  = clr;
        @(posedge clock);
        ev = 0;
        if (e && m == JK_UP && m_count == MAXV) ev = 1;
        if (e && m == JK_DOWN && m_count == 0) ev = 1;
        if (e) begin
            case (m)
                JK_UP:   m_count = (ev && Sat) ? m_count : (m_count + 1) % 16;
                JK_DOWN: m_count = (ev && Sat) ? m_count : (m_count + 15) % 16;
                JK_LOAD: m_count = lv % 16;
                default: ;
            endcase
        end
        m_wrap = ev;
        if (ev) m_ovf = 1;
        else if (clr) m_ovf = 0;
        #1;
        check_eq("count", int'(bus.count), m_count);
        check_eq("count_n", int'(bus.count_n), 15 - m_count);
        check_eq("wrap", int'(bus.wrap), m_wrap);
        check_eq("ovf", int'(bus.ovf), m_ovf);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_eq("rst_count", int'(bus.count), 0);
        check_eq("rst_ovf", int'(bus.ovf), 0);
    endtask

    initial begin
        int wraps;
        logic [3:0] lv;
        reset_n      = 1'b0;
        bus.en       = 1'b0;
        bus.mode     = JK_HOLD;
        bus.load_val = '0;
        bus.ovf_clr  = 1'b0;
        do_reset();

        // 1: asynchronous reset mid-count with ovf and count non-zero
        step(1'b1, JK_DOWN, 0, 1'b0);
        step(1'b1, JK_LOAD, 5, 1'b0);
        check_eq("t1_pre_count", int'(bus.count), 5);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("t1_async_count", int'(bus.count), 0);
        check_eq("t1_async_count_n", int'(bus.count_n), 15);
        check_eq("t1_async_wrap", int'(bus.wrap), 0);
        check_eq("t1_async_ovf", int'(bus.ovf), 0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;

        // 2: seventeen UP steps from 0
        wraps = 0;
        for (int i = 0; i < 17; i++) begin
            step(1'b1, JK_UP, 0, 1'b0);
            if (bus.wrap) wraps++;
        end
        check_eq("t2_final_count", int'(bus.count), Sat ? 15 : 1);
        check_eq("t2_wrap_pulses", wraps, Sat ? 2 : 1);
        check_eq("t2_ovf", int'(bus.ovf), 1);

        // 3: DOWN from 0, then on to 12
        do_reset();
        step(1'b1, JK_DOWN, 0, 1'b0);
        check_eq("t3_wrap", int'(bus.wrap), 1);
        wraps = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, JK_DOWN, 0, 1'b0);
            if (bus.wrap) wraps++;
        end
        check_eq("t3_no_more_wraps", wraps, Sat ? 3 : 0);

        // 4: LOAD then UP, LOAD at 15, en=0 with LOAD
        do_reset();
        step(1'b1, JK_LOAD, 10, 1'b0);
        check_eq("t4_load_a", int'(bus.count), 10);
        step(1'b1, JK_UP, 0, 1'b0);
        check_eq("t4_up_b", int'(bus.count), 11);
        step(1'b1, JK_LOAD, 15, 1'b0);
        step(1'b1, JK_LOAD, 15, 1'b0);
        check_eq("t4_load_at_max_wrap", int'(bus.wrap), 0);
        step(1'b0, JK_LOAD, 3, 1'b0);
        check_eq("t4_en0_load", int'(bus.count), 15);

        // 5: ovf_clr vs same-cycle wrap, then a plain clear with en=0
        step(1'b1, JK_UP, 0, 1'b1);
        check_eq("t5_set_wins", int'(bus.ovf), 1);
        step(1'b0, JK_HOLD, 0, 1'b1);
        check_eq("t5_clear", int'(bus.ovf), 0);

        // 6: randomized stimulus
        for (int i = 0; i < 10000; i++) begin
            lv = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 7) != 0), jk_mode_e'($urandom_range(0, 3)),
                 int'(lv), ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
